// File: rtl/aes_pkg.sv
// Shared AES-128 types and tables for the iterative decipher core.
// Holds the forward/inverse S-boxes, the Rcon table, the state array type and the FSM encoding.
package aes_pkg;

    // Indexed [column][row]; element [0][0] is byte 0 at bits [127:120].
    typedef logic [0:3][0:3][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Valid entries are 1..10; the rest are zero so any 4-bit round index stays in range.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES-128 inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless last_round is set.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t   state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output aes_state_t   state_out
);

    aes_state_t sub_bytes;
    aes_state_t add_key;
    aes_state_t mixed;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {x14, x13, x11, x9} of one byte.
    function automatic logic [31:0] inv_mul(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return {b8 ^ b4 ^ b2, b8 ^ b4 ^ b, b8 ^ b2 ^ b, b8 ^ b};
    endfunction

    always_comb begin
        sub_bytes = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_bytes[c][r] = INV_SBOX[state_in[(c + 4 - r) % 4][r]];
            end
        end
    end

    assign add_key = sub_bytes ^ round_key;

    always_comb begin
        logic [31:0] m0, m1, m2, m3;
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            m0 = inv_mul(add_key[c][0]);
            m1 = inv_mul(add_key[c][1]);
            m2 = inv_mul(add_key[c][2]);
            m3 = inv_mul(add_key[c][3]);
            // fields: [31:24]=x14 [23:16]=x13 [15:8]=x11 [7:0]=x9
            mixed[c][0] = m0[31:24] ^ m1[15:8]  ^ m2[23:16] ^ m3[7:0];
            mixed[c][1] = m0[7:0]   ^ m1[31:24] ^ m2[15:8]  ^ m3[23:16];
            mixed[c][2] = m0[23:16] ^ m1[7:0]   ^ m2[31:24] ^ m3[15:8];
            mixed[c][3] = m0[15:8]  ^ m1[23:16] ^ m2[7:0]   ^ m3[31:24];
        end
    end

    assign state_out = last_round ? add_key : mixed;

endmodule

// File: rtl/aes_decipher_core.sv
// Iterative AES-128 decipher core: one inverse round per enabled cycle, key schedule run backwards.
// Define AES_DECIPHER_KEY_OUT_EN to expose the recovered cipher key on round_key_0_out.
module aes_decipher_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] cipher_text_in,
    input  logic [127:0] round_key_10,
    input  logic         decipher_new_en,
    output logic [127:0] plain_text_out,
    output logic         decipher_ready
`ifdef AES_DECIPHER_KEY_OUT_EN
    ,
    output logic [127:0] round_key_0_out
`endif
);

    aes_fsm_t     state, state_nxt;
    logic [3:0]   rnd;
    aes_state_t   state_reg;
    aes_state_t   round_out;
    logic [127:0] key_reg;
    logic [127:0] key_prev;
    logic         accept;
    logic         last_round;

    assign accept     = en && decipher_new_en && (state == IDLE || state == DONE);
    assign last_round = (rnd == 4'd1);

    // Undo one key-expansion step; Rcon[rnd] produced key_reg from key_prev.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, rot;
        w0  = key_reg[127:96];
        w1  = key_reg[95:64] ^ key_reg[127:96];
        w2  = key_reg[63:32] ^ key_reg[95:64];
        w3  = key_reg[31:0]  ^ key_reg[63:32];
        rot = {w3[23:0], w3[31:24]};
        w0  = w0 ^ {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
                 ^ {RCON[rnd], 24'h0};
        key_prev = {w0, w1, w2, w3};
    end

    aes_inv_round u_inv_round (
        .state_in   (state_reg),
        .round_key  (key_prev),
        .last_round (last_round),
        .state_out  (round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (accept) state_nxt = ROUND;
            ROUND:      if (en && last_round) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd            <= 4'd0;
            state_reg      <= '0;
            key_reg        <= '0;
            plain_text_out <= '0;
            decipher_ready <= 1'b0;
`ifdef AES_DECIPHER_KEY_OUT_EN
            round_key_0_out <= '0;
`endif
        end else if (accept) begin
            state_reg      <= cipher_text_in ^ round_key_10;
            key_reg        <= round_key_10;
            rnd            <= 4'd10;
            decipher_ready <= 1'b0;
        end else if (state == ROUND && en) begin
            state_reg <= round_out;
            key_reg   <= key_prev;
            rnd       <= rnd - 4'd1;
            if (last_round) begin
                plain_text_out <= round_out;
                decipher_ready <= 1'b1;
`ifdef AES_DECIPHER_KEY_OUT_EN
                round_key_0_out <= key_prev;
`endif
            end
        end
    end

endmodule

// File: doc/aes_decipher_core.md
AES_DECIPHER_CORE -- requirements
Module: aes_decipher_core

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 128-bit block and 128-bit key (AES-128 only).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port en, input, 1 bit: global enable; while low, all registers hold.
REQ-005 SHALL have port cipher_text_in, input, 128 bits: ciphertext block, byte 0 in bits [127:120].
REQ-006 SHALL have port round_key_10, input, 128 bits: final encryption round key, as produced by the encrypt core.
REQ-007 SHALL have port decipher_new_en, input, 1 bit: start request; single-cycle pulse or level.
REQ-008 SHALL have port plain_text_out, output, 128 bits: registered plaintext result.
REQ-009 SHALL have port decipher_ready, output, 1 bit: registered flag; high when plain_text_out holds a valid result.

Function
REQ-010 SHALL use an FSM with states IDLE, ROUND and DONE, plus a 4-bit round counter rnd.
REQ-011 Accept condition: en=1, decipher_new_en=1 and state is IDLE or DONE.
REQ-012 On accept, SHALL load state_reg=cipher_text_in^round_key_10, key_reg=round_key_10, rnd=10, and clear decipher_ready, then enter ROUND.
REQ-013 In ROUND with en=1, each cycle SHALL derive the previous round key from key_reg using Rcon[rnd]:
- w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
- w0'=w0^SubWord(RotWord(w3'))^Rcon[rnd].
REQ-014 For rnd 10..2, SHALL load state_reg=InvMixColumns(InvSubBytes(InvShiftRows(state_reg))^key_prev) and key_reg=key_prev, then decrement rnd.
REQ-015 For rnd=1, SHALL omit InvMixColumns, load plain_text_out with the result, set decipher_ready=1, and enter DONE.
REQ-016 Latency: accept edge E0 SHALL be followed by decipher_ready=1 after edge E10 (10 enabled cycles).
REQ-017 In DONE, plain_text_out and decipher_ready SHALL hold until the next accept.
REQ-018 decipher_new_en asserted during ROUND SHALL be ignored and SHALL NOT be queued.
REQ-019 en=0 during ROUND SHALL stall the iteration exactly; the result SHALL be bit-identical, with latency extended by the stalled cycles.
REQ-020 Accept in DONE SHALL drop decipher_ready on the accept edge; back-to-back blocks therefore need 11 cycles each.
REQ-021 cipher_text_in and round_key_10 SHALL be sampled only on the accept edge; later changes SHALL NOT affect the result.

Reset
REQ-022 Asserting reset at any time SHALL immediately force IDLE, rnd=0, state_reg=0, key_reg=0, plain_text_out=0 and decipher_ready=0.
REQ-023 Reset mid-operation SHALL abandon the block; no result SHALL be produced after release without a new accept.

Configuration
REQ-024 Macro AES_DECIPHER_KEY_OUT_EN:
- Defined: SHALL add output round_key_0_out (128 bits), registered in DONE, equal to the recovered cipher key and reset to 0.
- Undefined: the port and its register SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-025 Package aes_pkg SHALL hold:
- forward and inverse S-box constant tables;
- the Rcon table (index 1..10);
- typedef aes_state_t (4x4 byte array);
- the FSM state enum.
REQ-026 Sub-module aes_inv_round SHALL be purely combinational (state, key, last_round flag -> next state) and SHALL be instantiated once.

Verification
REQ-027 FIPS-197 App.B: rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, ct=3925841d02dc09fbdc118597196a0b32 -> plain_text_out=3243f6a8885a308d313198a2e0370734 and decipher_ready high exactly 10 cycles after accept.
REQ-028 FIPS-197 App.C.1: rk10=13111d7fe3944a17f307a78b4d2b30c5, ct=69c4e0d86a7b0430d8cdb78070b4c55a -> pt=00112233445566778899aabbccddeeff; with the macro defined, round_key_0_out=000102030405060708090a0b0c0d0e0f.
REQ-029 App.B vector with en low for 3 cycles at rnd=6 -> same pt, ready after 13 cycles; decipher_new_en pulsed at rnd=4 -> ignored.
REQ-030 Reset asserted at rnd=5, then released -> all outputs 0 and stay 0; a new accept of the App.C.1 vector -> correct pt after 10 cycles.
REQ-031 App.B vector accepted in the cycle decipher_ready rises, followed by App.C.1 -> ready drops on the accept edge and both results are correct in order.
